// File: rtl/pe_pkg.sv
// Shared types and defaults for the pe_stream_packer slice.
// Saturating narrowing is enabled by defining PE_SATURATE_EN.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_COMMIT,
    ST_STORE
  } pe_state_e;

  localparam int PE_DATA_W    = 8;
  localparam int PE_ACC_W     = 24;
  localparam int PE_OUT_W     = 8;
  localparam int PE_SHIFT     = 0;
  localparam int PE_PACK      = 4;
  localparam int PE_MEM_DEPTH = 128;

  // Clamp a signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_stream_packer_if.sv
// Beat stream, flush, read port and status of pe_stream_packer.
// master = controller side, slave = the packer itself.
interface pe_stream_packer_if
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int OUT_W  = PE_OUT_W,
  parameter int PACK   = PE_PACK,
  parameter int ADR_W  = $clog2(PE_MEM_DEPTH)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_pixel;
  logic [DATA_W-1:0]       in_weight;
  logic                    in_last;
  logic                    flush;
  logic                    rd_en;
  logic [ADR_W-1:0]        rd_adr;
  logic [PACK*OUT_W-1:0]   rd_data;
  logic [ADR_W:0]          lines;
  logic                    full;
  logic                    overflow;

  modport master (
    output in_valid, in_pixel, in_weight, in_last,
    output flush, rd_en, rd_adr,
    input  in_ready, rd_data, lines, full, overflow
  );

  modport slave (
    input  in_valid, in_pixel, in_weight, in_last,
    input  flush, rd_en, rd_adr,
    output in_ready, rd_data, lines, full, overflow
  );

endinterface

// File: rtl/pe_mac_acc.sv
// Signed multiply-accumulate with clear and enable.
// Products are sign-extended and the sum wraps modulo 2^ACC_W.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_a * i_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pe_stream_packer.sv
// MAC processing element packing PACK results per line into a result memory.
// Define PE_SATURATE_EN to clamp results instead of wrapping.
module pe_stream_packer
  import pe_pkg::*;
#(
  parameter int DATA_W    = PE_DATA_W,
  parameter int ACC_W     = PE_ACC_W,
  parameter int OUT_W     = PE_OUT_W,
  parameter int SHIFT     = PE_SHIFT,
  parameter int PACK      = PE_PACK,
  parameter int MEM_DEPTH = PE_MEM_DEPTH
) (
  input logic               clk,
  input logic               rst,
  pe_stream_packer_if.slave s
);

  localparam int ADR_W  = $clog2(MEM_DEPTH);
  localparam int LW     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int LINE_W = PACK * OUT_W;

  pe_state_e         r_state;
  logic              r_ready;
  logic [LW-1:0]     r_idx;
  logic [LINE_W-1:0] r_line;
  logic [ADR_W:0]    r_lines;
  logic              r_ovf;
  logic              r_fpend;
  logic [LINE_W-1:0] r_rd;
  logic [LINE_W-1:0] r_mem [MEM_DEPTH];

  logic                    w_fire;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_lane_end;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_shr;
  logic [OUT_W-1:0]        w_res;

  assign w_fire     = s.in_valid & r_ready;
  assign w_full     = (r_lines == (ADR_W+1)'(MEM_DEPTH));
  assign w_wr       = (r_state == ST_STORE) & ~w_full;
  assign w_lane_end = (r_idx == LW'(PACK - 1));

  pe_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_fire),
    .i_clr (r_state == ST_COMMIT),
    .i_a   (s.in_pixel),
    .i_b   (s.in_weight),
    .o_acc (w_acc)
  );

  assign w_shr = w_acc >>> SHIFT;

`ifdef PE_SATURATE_EN
  assign w_res = OUT_W'(sat_clamp(64'(w_shr), OUT_W));
`else
  assign w_res = OUT_W'(w_shr);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_ready <= 1'b1;
      r_idx   <= '0;
      r_line  <= '0;
      r_lines <= '0;
      r_ovf   <= 1'b0;
      r_fpend <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ACC: begin
          if (w_fire && s.in_last) begin
            r_state <= ST_COMMIT;
            r_ready <= 1'b0;
            r_fpend <= s.flush;
          end else if (s.flush && r_idx != '0) begin
            // a beat taken this cycle stays in acc for the next result
            r_state <= ST_STORE;
            r_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_line[r_idx*OUT_W +: OUT_W] <= w_res;
          r_idx   <= r_idx + 1'b1;
          r_fpend <= 1'b0;
          if (w_lane_end || r_fpend || s.flush) begin
            r_state <= ST_STORE;
            r_ready <= 1'b0;
          end else begin
            r_state <= ST_ACC;
            r_ready <= 1'b1;
          end
        end
        ST_STORE: begin
          if (!w_full) r_lines <= r_lines + 1'b1;
          else         r_ovf   <= 1'b1;
          r_line  <= '0;
          r_idx   <= '0;
          r_fpend <= 1'b0;
          r_state <= ST_ACC;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_ACC;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Memory is not reset; the read sees pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_lines[ADR_W-1:0]] <= r_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
    end else if (s.rd_en) begin
      r_rd <= r_mem[s.rd_adr];
    end
  end

  assign s.in_ready = r_ready;
  assign s.rd_data  = r_rd;
  assign s.lines    = r_lines;
  assign s.full     = w_full;
  assign s.overflow = r_ovf;

endmodule

// File: tb/tb_pe_stream_packer.sv
// Directed bench: a default-depth packer and a 4-line packer share one stimulus.
// Expected line values are hand-computed; PE_SATURATE_EN selects the clamp case.
module tb_pe_stream_packer;
  import pe_pkg::*;

`ifdef PE_SATURATE_EN
  localparam logic [31:0] SAT_LINE = 32'h0000_7F7F;
`else
  localparam logic [31:0] SAT_LINE = 32'h0000_0101;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   w;

  always #5 clk = ~clk;

  pe_stream_packer_if #(.DATA_W(8), .OUT_W(8), .PACK(4), .ADR_W(7)) pa ();
  pe_stream_packer_if #(.DATA_W(8), .OUT_W(8), .PACK(4), .ADR_W(2)) pb ();

  assign pb.in_valid  = pa.in_valid;
  assign pb.in_pixel  = pa.in_pixel;
  assign pb.in_weight = pa.in_weight;
  assign pb.in_last   = pa.in_last;
  assign pb.flush     = pa.flush;
  assign pb.rd_en     = pa.rd_en;
  assign pb.rd_adr    = pa.rd_adr[1:0];

  pe_stream_packer #(.MEM_DEPTH(128)) u_dut (
    .clk (clk),
    .rst (rst),
    .s   (pa)
  );

  pe_stream_packer #(.MEM_DEPTH(4)) u_small (
    .clk (clk),
    .rst (rst),
    .s   (pb)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pa.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("ready_timeout", 64'(n), 64'(0));
  endtask

  // Offer one beat; valid stays high afterwards until idle().
  task automatic beat(input logic [7:0] p, input logic [7:0] q,
                      input logic l, input logic f, output int waits);
    waits = 0;
    @(negedge clk);
    pa.in_valid  = 1'b1;
    pa.in_pixel  = p;
    pa.in_weight = q;
    pa.in_last   = l;
    pa.flush     = f;
    while (!pa.in_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 8) chk("beat_timeout", 64'(waits), 64'(0));
    @(posedge clk);
    #1 pa.flush = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    pa.in_valid = 1'b0;
    pa.in_last  = 1'b0;
    wait_ready();
  endtask

  task automatic do_flush();
    @(negedge clk);
    pa.flush = 1'b1;
    @(negedge clk);
    pa.flush = 1'b0;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic rd(input logic [6:0] a);
    @(negedge clk);
    pa.rd_en  = 1'b1;
    pa.rd_adr = a;
    @(negedge clk);
    pa.rd_en  = 1'b0;
  endtask

  initial begin
    pa.in_valid  = 1'b0;
    pa.in_pixel  = '0;
    pa.in_weight = '0;
    pa.in_last   = 1'b0;
    pa.flush     = 1'b0;
    pa.rd_en     = 1'b0;
    pa.rd_adr    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", 64'(pa.in_ready), 64'(1));
    chk("rst_lines", 64'(pa.lines), 64'(0));
    chk("rst_full", 64'(pa.full), 64'(0));
    chk("rst_ovf", 64'(pa.overflow), 64'(0));
    chk("rst_rdata", 64'(pa.rd_data), 64'(0));

    // 3*4 - 2*5 + 1*1 = 3, four times -> one full line
    for (int i = 0; i < 4; i++) begin
      beat(8'd3, 8'd4, 1'b0, 1'b0, w);
      if (i > 0) chk("dp_gap", 64'(w), 64'(1));
      beat(8'hFE, 8'd5, 1'b0, 1'b0, w);
      beat(8'd1, 8'd1, 1'b1, 1'b0, w);
    end
    idle();
    chk("line0_lines", 64'(pa.lines), 64'(1));
    rd(7'd0);
    chk("line0_data", 64'(pa.rd_data), 64'h0303_0303);

    // single-beat products with valid held high across COMMIT/STORE
    beat(8'd5, 8'd1, 1'b1, 1'b0, w);
    beat(8'd2, 8'd3, 1'b1, 1'b0, w);
    chk("hold_gap1", 64'(w), 64'(1));
    beat(8'hFF, 8'd7, 1'b1, 1'b0, w);
    chk("hold_gap2", 64'(w), 64'(1));
    beat(8'd10, 8'hF6, 1'b1, 1'b0, w);
    chk("hold_gap3", 64'(w), 64'(1));
    beat(8'd1, 8'd1, 1'b1, 1'b0, w);
    chk("hold_gap_store", 64'(w), 64'(2));
    beat(8'hFD, 8'd1, 1'b1, 1'b0, w);
    chk("hold_gap4", 64'(w), 64'(1));
    idle();
    chk("line1_lines", 64'(pa.lines), 64'(2));
    rd(7'd1);
    chk("line1_data", 64'(pa.rd_data), 64'h9CF9_0605);

    // partial line of two results, then flush with an empty line
    do_flush();
    chk("flush_lines", 64'(pa.lines), 64'(3));
    rd(7'd2);
    chk("flush_data", 64'(pa.rd_data), 64'h0000_FD01);
    do_flush();
    chk("flush_empty", 64'(pa.lines), 64'(3));

    // 127*127 = 16129 (0x3F01)
    beat(8'd127, 8'd127, 1'b1, 1'b0, w);
    beat(8'd127, 8'd127, 1'b1, 1'b0, w);
    idle();
    do_flush();
    rd(7'd3);
    chk("sat_data", 64'(pa.rd_data), 64'(SAT_LINE));
    chk("small_lines", 64'(pb.lines), 64'(4));
    chk("small_full", 64'(pb.full), 64'(1));
    chk("small_ovf0", 64'(pb.overflow), 64'(0));
    chk("big_full", 64'(pa.full), 64'(0));

    // flush together with the last beat -> store via pending flush
    beat(8'd1, 8'd1, 1'b1, 1'b1, w);
    idle();
    @(negedge clk);
    chk("pend_lines", 64'(pa.lines), 64'(5));
    chk("small_ovf1", 64'(pb.overflow), 64'(1));
    chk("small_lines2", 64'(pb.lines), 64'(4));
    rd(7'd4);
    chk("pend_data", 64'(pa.rd_data), 64'h0000_0001);
    rd(7'd3);
    chk("small_keep", 64'(pb.rd_data), 64'(SAT_LINE));

    // reset in the middle of a dot product
    beat(8'd5, 8'd5, 1'b0, 1'b0, w);
    beat(8'd6, 8'd6, 1'b0, 1'b0, w);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_lines", 64'(pa.lines), 64'(0));
    chk("mid_rst_ready", 64'(pa.in_ready), 64'(1));
    chk("mid_rst_ovf", 64'(pb.overflow), 64'(0));
    chk("mid_rst_full", 64'(pb.full), 64'(0));
    chk("mid_rst_rdata", 64'(pa.rd_data), 64'(0));
    beat(8'd2, 8'd3, 1'b1, 1'b0, w);
    idle();
    do_flush();
    chk("post_rst_lines", 64'(pa.lines), 64'(1));
    rd(7'd0);
    chk("post_rst_data", 64'(pa.rd_data), 64'h0000_0006);
    rd(7'd1);
    chk("mem_kept", 64'(pa.rd_data), 64'h9CF9_0605);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pe_stream_packer.md
# pe_stream_packer

Parametrised processing element for the convolution datapath: accepts a valid/ready stream of pixel/weight pairs, multiply-accumulates each dot product, scales it down to an output word, packs PACK outputs into one line and stores lines into an internal result memory with an auto-incrementing write pointer. A synchronous read port, full/overflow flags and an explicit flush of partial lines let the controller drain results without knowing the line geometry.

## Interface
- DATA_W, 8: pixel and weight width, signed two's complement
- ACC_W, 24: accumulator width, at least 2*DATA_W
- OUT_W, 8: stored result word width
- SHIFT, 0: arithmetic right shift applied to the accumulator before narrowing
- PACK, 4: result words per memory line, at least 1
- MEM_DEPTH, 128: lines in result memory; ADR_W = $clog2(MEM_DEPTH)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel/weight beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_pixel  in  DATA_W  image pixel
- in_weight  in  DATA_W  filter value
- in_last  in  1  final beat of current dot product
- flush  in  1  single-cycle request to store a partial line
- rd_en  in  1  read request
- rd_adr  in  ADR_W  read line address
- rd_data  out  PACK*OUT_W  line read; lane 0 in LSBs
- lines  out  ADR_W+1  lines stored so far
- full  out  1  lines == MEM_DEPTH
- overflow  out  1  sticky: a line was dropped because memory was full

## Operation
- FSM states ACC, COMMIT, STORE. Reset -> ACC.
- ACC: in_ready = 1. Each accepted beat: acc += sext(pixel*weight) (signed product, 2*DATA_W, sign-extended to ACC_W, wraps modulo 2^ACC_W). Beat with in_last -> COMMIT.
- COMMIT: in_ready = 0. res = acc >>> SHIFT, narrowed to OUT_W (see Configuration), written to lane[lane_idx]; acc <= 0; lane_idx++. If lane_idx was PACK-1 or flush pending -> STORE, else -> ACC.
- STORE: in_ready = 0. If !full: mem[lines] <= packed line, lines++. If full: line dropped, overflow <= 1. Lanes and lane_idx cleared, flush_pending cleared -> ACC.
- flush in ACC with lane_idx != 0 -> STORE next cycle (unused lanes stored as zero). flush in ACC with lane_idx == 0 ignored. flush during COMMIT or together with an accepted in_last beat sets flush_pending. flush during STORE ignored.
- Partial accumulation (beats accepted without in_last) is not affected by flush.
- Read port independent of FSM; rd_adr >= lines returns unspecified contents; no out-of-range error.
- Reset mid-operation: acc, lanes, lane_idx, lines, overflow, flush_pending cleared; memory contents not cleared.
- Reset values: in_ready 1 (state ACC), rd_data 0, lines 0, full 0, overflow 0.

## Timing
- Last beat accepted cycle t: COMMIT t+1; STORE t+2 if line completes; in_ready back high at t+2 (no store) or t+3 (store).
- lines/full updated at the edge ending STORE; mem write on same edge; read of that line valid if rd_en issued the following cycle.
- Read latency 1: rd_en at cycle t -> rd_data valid t+1, held until next rd_en or reset.
- Simultaneous read and write of the same address: rd_data returns old contents.
- Single-beat dot products legal: peak throughput one result per 2 cycles (3 on line completion).

## Configuration
- PE_SATURATE_EN defined: res clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: res = low OUT_W bits of shifted accumulator (wrap).

## Structure
- Package pe_pkg: state enum (ACC, COMMIT, STORE), helper function for signed clamp, default parameter localparams.
- One sub-module: pe_mac_acc (multiplier, accumulator, clear and enable), instantiated once; FSM, lane buffer and memory in top.

## Test plan
- Defaults, beats (3,4),(-2,5),(1,1,last) -> res 3; four such dot products -> mem[0] = 0x03030303, lines 1.
- Two dot products then flush -> mem[0] lanes {0,0,r1,r0}, lines 1; flush with lane_idx 0 -> no write.
- SATURATE_EN, beats (127,127,last) twice -> lane 127 each; undefined macro -> lane 0x01 (16129 low byte).
- MEM_DEPTH 4: store 5 lines -> full 1 after 4th, overflow 1 after 5th, lines 4, mem[3] intact.
- in_valid held high across COMMIT/STORE -> no beat lost or duplicated; in_ready low exactly 1 or 2 cycles.
- Reset asserted mid dot product -> lines 0, in_ready 1, next dot product result unaffected by previous partial acc.
